// File: rtl/systolic_result_serializer.sv
// rtl/systolic_result_serializer.sv - row FIFO plus element serializer for systolic array result rows
// Optional feature macro: SYSTOLIC_RESULT_RELU_EN (negative elements clamp to zero at output load)
module systolic_result_serializer #(
  parameter int MATRIX_SIZE = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 5
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              clr,
  input  logic                              row_valid,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] row_data,
  input  logic                              matrix_done,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic                              m_row_end,
  output logic                              m_last,
  output logic                              busy,
  output logic                              overflow,
  output logic                              frame_err
);

  localparam int ROW_W = MATRIX_SIZE * DATA_WIDTH;
  localparam int COL_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_SIZE - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                state;
  state_t                state_next;
  logic [ROW_W-1:0]      fifo_row  [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [COL_W-1:0]      wr_row;
  logic [COL_W-1:0]      wr_row_adv;
  logic [COL_W-1:0]      col;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  load;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  last_tag;
  logic [DATA_WIDTH-1:0] head_elem;
  logic [DATA_WIDTH-1:0] load_elem;

  // Handshake decode: output load, head pop, row push/drop and the advanced write-row index
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_FULL);
    load       = (!m_valid || m_ready) && !fifo_empty;
    pop        = load && (col == COL_LAST);
    push       = row_valid && (!fifo_full || pop);
    drop       = row_valid && fifo_full && !pop;
    last_tag   = (wr_row == COL_LAST);
    wr_row_adv = wr_row;
    if (row_valid) begin
      wr_row_adv = (wr_row == COL_LAST) ? '0 : wr_row + 1'b1;
    end
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // Select the current column of the head row and apply the optional clamp
  always_comb begin
    head_elem = fifo_row[rd_ptr][32'(col)*DATA_WIDTH +: DATA_WIDTH];
`ifdef SYSTOLIC_RESULT_RELU_EN
    load_elem = head_elem[DATA_WIDTH-1] ? '0 : head_elem;
`else
    load_elem = head_elem;
`endif
  end

  // Row storage; no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      fifo_row[wr_ptr]  <= row_data;
      fifo_last[wr_ptr] <= last_tag;
    end
  end

  // FIFO pointers, occupancy, column/row counters and sticky flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_row    <= '0;
      col       <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_row    <= '0;
      col       <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      count <= count_next;
      if (load) begin
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      // A dropped row still advances framing, so the check uses the advanced index
      if (matrix_done) begin
        if (wr_row_adv != '0) begin
          frame_err <= 1'b1;
        end
        wr_row <= '0;
      end else begin
        wr_row <= wr_row_adv;
      end
    end
  end

  // Output register: load the next element or retire it on handshake; payload holds otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_row_end <= 1'b0;
      m_last    <= 1'b0;
    end else if (clr) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_row_end <= 1'b0;
      m_last    <= 1'b0;
    end else if (load) begin
      m_valid   <= 1'b1;
      m_data    <= load_elem;
      m_row_end <= (col == COL_LAST);
      m_last    <= (col == COL_LAST) && fifo_last[rd_ptr];
    end else if (m_ready) begin
      m_valid   <= 1'b0;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Serializer next-state: idle, streaming rows, or draining the last held element
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_next = S_STREAM;
      end
      S_STREAM: begin
        if (pop && (count_next == '0)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (push) begin
          state_next = S_STREAM;
        end else if (m_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Serializer outputs: busy whenever a row is queued or an element is still held
  always_comb begin
    busy = (state != S_IDLE) || !fifo_empty;
  end

endmodule
